core_mem_stage: RTL and testbench
=================================

# core_mem_stage

Responder for the core's MEM-stage valid/ready handshake. It accepts a load/store request from the core controller, runs one word-aligned transaction on the data bus with a req/ack handshake, and returns one completion pulse on `mem_stage_ready`. Completion data is lane-extracted and sign- or zero-extended for write-back. The block also handles byte strobes, misalignment faults and a bus watchdog.

## Interface
- `TIMEOUT`, 255: max cycles `bus_req` waits for `bus_ack` before a fault; 0 disables the watchdog.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `mem_stage_valid`  in  1  controller is in MEM state; request fields are stable while high.
- `mem_stage_ready`  out  1  one-cycle completion pulse.
- `mem_write`  in  1  1 = store, 0 = load.
- `mem_funct3`  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  store data (rs2).
- `mem_rdata`  out  32  load result; valid in the `mem_stage_ready` cycle and held until the next completion.
- `mem_fault`  out  1  access fault; valid with `mem_stage_ready` and held like `mem_rdata`.
- `bus_req`  out  1  transaction request.
- `bus_we`  out  1  write enable.
- `bus_addr`  out  32  word address, [1:0] always 0.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_wstrb`  out  4  byte strobes; 0000 on reads.
- `bus_ack`  in  1  completes the transaction in any cycle where `bus_req` is high.
- `bus_rdata`  in  32  read word; valid with `bus_ack`.
- `bus_err`  in  1  bus error; sampled only with `bus_ack`.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE**
  - On `mem_stage_valid`: check the request.
  - Illegal request goes to DONE with fault, and no bus access occurs. Illegal means funct3 ∈ {011, 110, 111}, or a store with funct3[2] = 1, or misalignment (H/HU with addr[0] = 1; W with addr[1:0] ≠ 00).
  - Otherwise, latch the bus fields and go to REQ.
- **REQ**
  - `bus_req` = 1 and all bus outputs stay constant.
  - On `bus_ack`, go to DONE: fault = `bus_err`; for loads, latch the extracted data.
  - On timeout (`TIMEOUT` ≠ 0 and the wait counter reaches `TIMEOUT` − 1 without ack), go to DONE with fault; `bus_req` falls.
- **DONE**: `mem_stage_ready` = 1 for exactly one cycle, then IDLE.
- Store data and strobes:
  - SB: wdata = {4{wdata[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{wdata[15:0]}}, wstrb = 0011 << addr[1:0].
  - SW: wdata unchanged, wstrb = 1111.
- Load data:
  - Select the byte or half at addr[1:0] from `bus_rdata`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
  - Any fault forces `mem_rdata` = 0.
- Stores complete with `mem_rdata` = 0.
- If `mem_stage_valid` drops mid-REQ (a protocol violation), the bus transaction still finishes and the ready pulse is still issued.
- The watchdog counter clears on entry to REQ and saturates; its width is clog2(`TIMEOUT` + 1).

## Timing
- Reset values: state IDLE; `mem_stage_ready`, `mem_fault`, `bus_req`, `bus_we` = 0; `mem_rdata`, `bus_addr`, `bus_wdata` = 0; `bus_wstrb` = 0000.
- Legal request:
  - valid seen at cycle 0.
  - `bus_req` rises at cycle 1.
  - ack at cycle k ≥ 1.
  - `mem_stage_ready` at cycle k + 1.
  - Minimum is 3 cycles of valid.
- Illegal request: ready at cycle 1, `bus_req` never asserted.
- Timeout: `bus_req` is high for exactly `TIMEOUT` cycles; ready follows in the next cycle.
- All outputs are registered; there is no combinational path from `mem_stage_valid` or `bus_ack` to any output.
- No request is accepted in DONE. IDLE re-samples valid in the cycle after DONE, so the controller must have left MEM by then, which it does one cycle after ready.
- Reset in REQ: `bus_req` is 0 after the reset edge and the transaction is abandoned. Reset in DONE: the ready pulse is suppressed from the next edge.

## Test plan
- LW at 0x100, slave acks 2 cycles after req with 0xDEADBEEF → `bus_addr` 0x100, `bus_wstrb` 0000, ready at cycle 3, `mem_rdata` 0xDEADBEEF, fault 0.
- LB at 0x103 and LBU at 0x103, slave data 0x80112233 → `mem_rdata` 0xFFFFFF80 and 0x00000080; LH at 0x102 → 0xFFFF8011.
- SB at 0x201 with wdata 0x000000A5 → `bus_addr` 0x200, `bus_wdata` 0xA5A5A5A5, `bus_wstrb` 0010, `bus_we` 1; SH at 0x202 with wdata 0x1234 → `bus_wdata` 0x12341234, `bus_wstrb` 1100.
- Misaligned LW at 0x102, and SH with funct3 101 → ready at cycle 1, fault 1, `mem_rdata` 0, `bus_req` never high.
- `TIMEOUT` = 4, slave never acks → `bus_req` high for cycles 1–4, ready at cycle 5 with fault 1; `bus_ack` with `bus_err` = 1 → fault 1, `mem_rdata` 0.
- Assert `rst` while in REQ → next cycle `bus_req` 0, no ready pulse; a following LW completes normally.

Source files
------------

// File: rtl/core_mem_stage.sv
// MEM-stage load/store responder: one word-aligned bus transaction per accepted
// request, lane steering for stores, extraction and extension for loads, watchdog.
module core_mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stage_valid,
    output logic        mem_stage_ready,
    input  logic        mem_write,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    // A zero TIMEOUT still needs a one-bit counter to keep the declarations legal.
    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
    localparam bit               WDOG_ON  = (TIMEOUT != 0);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        f3_reg, f3_next;
    logic [1:0]        off_reg, off_next;
    logic              ready_reg, ready_next;
    logic              fault_reg, fault_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [31:0]       addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [3:0]        wstrb_reg, wstrb_next;

    logic [31:0] sb_data;
    logic [31:0] sh_data;
    logic [7:0]  rd_byte [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign sb_data[8*gi +: 8] = mem_wdata[7:0];
            assign sh_data[8*gi +: 8] = mem_wdata[8*(gi % 2) +: 8];
            assign rd_byte[gi]        = bus_rdata[8*gi +: 8];
        end
    endgenerate

    // Request legality: reserved funct3, unsigned store, or misalignment.
    logic bad_f3;
    logic misaligned;
    logic illegal;

    always_comb begin
        bad_f3     = 1'b0;
        misaligned = 1'b0;
        case (mem_funct3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = mem_addr[0];
            3'b010:         misaligned = |mem_addr[1:0];
            default:        bad_f3     = 1'b1;
        endcase
        illegal = bad_f3 | (mem_write & mem_funct3[2]) | misaligned;
    end

    logic [31:0] st_data;
    logic [3:0]  st_strb;

    always_comb begin
        st_data = mem_wdata;
        st_strb = 4'b1111;
        case (mem_funct3[1:0])
            2'b00: begin
                st_data = sb_data;
                st_strb = 4'b0001 << mem_addr[1:0];
            end
            2'b01: begin
                st_data = sh_data;
                st_strb = 4'b0011 << mem_addr[1:0];
            end
            default: begin
                st_data = mem_wdata;
                st_strb = 4'b1111;
            end
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = rd_byte[off_reg];
        ld_half = off_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_reg)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        f3_next    = f3_reg;
        off_next   = off_reg;
        ready_next = 1'b0;
        fault_next = fault_reg;
        rdata_next = rdata_reg;
        req_next   = req_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wstrb_next = wstrb_reg;

        case (state_reg)
            ST_IDLE: begin
                if (mem_stage_valid) begin
                    if (illegal) begin
                        state_next = ST_DONE;
                        ready_next = 1'b1;
                        fault_next = 1'b1;
                        rdata_next = 32'd0;
                    end else begin
                        state_next = ST_REQ;
                        req_next   = 1'b1;
                        we_next    = mem_write;
                        addr_next  = {mem_addr[31:2], 2'b00};
                        wdata_next = mem_write ? st_data : 32'd0;
                        wstrb_next = mem_write ? st_strb : 4'b0000;
                        f3_next    = mem_funct3;
                        off_next   = mem_addr[1:0];
                        cnt_next   = '0;
                    end
                end
            end

            ST_REQ: begin
                // An ack in the final watchdog cycle still wins over the timeout.
                if (bus_ack) begin
                    state_next = ST_DONE;
                    req_next   = 1'b0;
                    ready_next = 1'b1;
                    fault_next = bus_err;
                    rdata_next = (bus_err || we_reg) ? 32'd0 : ld_data;
                end else if (WDOG_ON && (cnt_reg == CNT_LAST)) begin
                    state_next = ST_DONE;
                    req_next   = 1'b0;
                    ready_next = 1'b1;
                    fault_next = 1'b1;
                    rdata_next = 32'd0;
                end else if (cnt_reg != CNT_SAT) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            f3_reg    <= 3'd0;
            off_reg   <= 2'd0;
            ready_reg <= 1'b0;
            fault_reg <= 1'b0;
            rdata_reg <= 32'd0;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            wstrb_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            f3_reg    <= f3_next;
            off_reg   <= off_next;
            ready_reg <= ready_next;
            fault_reg <= fault_next;
            rdata_reg <= rdata_next;
            req_reg   <= req_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wstrb_reg <= wstrb_next;
        end
    end

    assign mem_stage_ready = ready_reg;
    assign mem_fault       = fault_reg;
    assign mem_rdata       = rdata_reg;
    assign bus_req         = req_reg;
    assign bus_we          = we_reg;
    assign bus_addr        = addr_reg;
    assign bus_wdata       = wdata_reg;
    assign bus_wstrb       = wstrb_reg;

endmodule

// File: tb/tb_core_mem_stage.sv
// Directed bench for core_mem_stage: per-cycle comparison against a transaction
// model, plus literal expectations on the documented scenarios.
module tb_core_mem_stage;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_stage_valid = 1'b0;
    logic        mem_stage_ready;
    logic        mem_write = 1'b0;
    logic [2:0]  mem_funct3 = 3'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        mem_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_err = 1'b0;

    core_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_stage_valid (mem_stage_valid),
        .mem_stage_ready (mem_stage_ready),
        .mem_write       (mem_write),
        .mem_funct3      (mem_funct3),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_fault       (mem_fault),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_wstrb       (bus_wstrb),
        .bus_ack         (bus_ack),
        .bus_rdata       (bus_rdata),
        .bus_err         (bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: what every output must be in the current cycle.
    bit          chk_on = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_ready = 1'b0;
    logic        exp_fault = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_wdata = 32'd0;
    logic [3:0]  exp_wstrb = 4'd0;

    // Observations from the most recent transaction.
    int          cap_ready_cycle;
    int          cap_req_cycles;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit model_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if (wr && f3 >= 3'd4) return 1'b0;
        size = 1 << f3[1:0];
        return (int'(a[1:0]) % size) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] s;
        int v;
        s = w >> (8 * int'(off));
        case (f3)
            3'd0: begin v = int'(s[7:0]);  if (v >= 128)   v -= 256;   return 32'(v); end
            3'd4: return 32'(s[7:0]);
            3'd1: begin v = int'(s[15:0]); if (v >= 32768) v -= 65536; return 32'(v); end
            3'd5: return 32'(s[15:0]);
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0) return 32'(d[7:0]) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [1:0] off);
        int bytes;
        bytes = 1 << f3[1:0];
        return 4'(((1 << bytes) - 1) << off);
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("bus_req", 32'(bus_req), 32'(exp_req));
            check("mem_stage_ready", 32'(mem_stage_ready), 32'(exp_ready));
            check("mem_rdata", mem_rdata, exp_rdata);
            check("mem_fault", 32'(mem_fault), 32'(exp_fault));
            if (exp_req) begin
                check("bus_addr", bus_addr, exp_addr);
                check("bus_we", 32'(bus_we), 32'(exp_we));
                check("bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
                if (exp_we) check("bus_wdata", bus_wdata, exp_wdata);
            end
        end
    end

    // ack_cycle = 0 means the slave never acknowledges.
    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_cycle,
                           input logic [31:0] rword, input logic err);
        bit legal;
        int done_cycle;
        @(posedge clk); #1;
        mem_stage_valid = 1'b1;
        mem_write  = wr;
        mem_funct3 = f3;
        mem_addr   = addr;
        mem_wdata  = wdata;
        legal = model_legal(wr, f3, addr);
        if (!legal)            done_cycle = 1;
        else if (ack_cycle > 0) done_cycle = ack_cycle + 1;
        else                   done_cycle = TIMEOUT + 1;
        cap_ready_cycle = -1;
        cap_req_cycles  = 0;
        for (int c = 1; c <= done_cycle + 1; c++) begin
            @(posedge clk); #1;
            if (bus_req) begin
                cap_req_cycles++;
                if (c == 1) begin
                    cap_addr  = bus_addr;
                    cap_wdata = bus_wdata;
                    cap_wstrb = bus_wstrb;
                    cap_we    = bus_we;
                end
            end
            if (mem_stage_ready && cap_ready_cycle < 0) cap_ready_cycle = c;
            bus_ack   = 1'b0;
            bus_err   = 1'b0;
            exp_req   = legal && (c < done_cycle);
            exp_ready = (c == done_cycle);
            if (c == 1 && legal) begin
                exp_addr  = addr & 32'hFFFF_FFFC;
                exp_we    = wr;
                exp_wstrb = wr ? model_wstrb(f3, addr[1:0]) : 4'b0000;
                exp_wdata = model_wdata(f3, wdata);
            end
            if (c == done_cycle) begin
                exp_fault = !legal || (ack_cycle == 0) || err;
                exp_rdata = (exp_fault || wr) ? 32'd0 : model_load(f3, addr[1:0], rword);
            end
            if (legal && c == ack_cycle) begin
                bus_ack   = 1'b1;
                bus_rdata = rword;
                bus_err   = err;
            end
            if (c == done_cycle + 1) mem_stage_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset ready", 32'(mem_stage_ready), 32'd0);
        check("reset fault", 32'(mem_fault), 32'd0);
        check("reset rdata", mem_rdata, 32'd0);
        check("reset bus_we", 32'(bus_we), 32'd0);
        check("reset bus_addr", bus_addr, 32'd0);
        check("reset bus_wdata", bus_wdata, 32'd0);
        check("reset bus_wstrb", 32'(bus_wstrb), 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;

        // LW, ack in cycle 2
        run_txn(1'b0, 3'b010, 32'h100, 32'd0, 2, 32'hDEAD_BEEF, 1'b0);
        check("lw ready cycle", 32'(cap_ready_cycle), 32'd3);
        check("lw rdata", mem_rdata, 32'hDEAD_BEEF);
        check("lw fault", 32'(mem_fault), 32'd0);
        check("lw bus_addr", cap_addr, 32'h100);
        check("lw bus_wstrb", 32'(cap_wstrb), 32'd0);

        run_txn(1'b0, 3'b000, 32'h103, 32'd0, 1, 32'h8011_2233, 1'b0);
        check("lb 0x103", mem_rdata, 32'hFFFF_FF80);
        run_txn(1'b0, 3'b100, 32'h103, 32'd0, 3, 32'h8011_2233, 1'b0);
        check("lbu 0x103", mem_rdata, 32'h0000_0080);
        run_txn(1'b0, 3'b001, 32'h102, 32'd0, 1, 32'h8011_2233, 1'b0);
        check("lh 0x102", mem_rdata, 32'hFFFF_8011);
        run_txn(1'b0, 3'b101, 32'h102, 32'd0, 2, 32'h8011_2233, 1'b0);
        check("lhu 0x102", mem_rdata, 32'h0000_8011);
        run_txn(1'b0, 3'b000, 32'h100, 32'd0, 1, 32'h8011_2233, 1'b0);
        check("lb 0x100", mem_rdata, 32'h0000_0033);

        run_txn(1'b1, 3'b000, 32'h201, 32'h0000_00A5, 1, 32'd0, 1'b0);
        check("sb bus_addr", cap_addr, 32'h200);
        check("sb bus_wdata", cap_wdata, 32'hA5A5_A5A5);
        check("sb bus_wstrb", 32'(cap_wstrb), 32'b0010);
        check("sb bus_we", 32'(cap_we), 32'd1);
        check("sb rdata", mem_rdata, 32'd0);
        run_txn(1'b1, 3'b001, 32'h202, 32'h0000_1234, 2, 32'd0, 1'b0);
        check("sh bus_wdata", cap_wdata, 32'h1234_1234);
        check("sh bus_wstrb", 32'(cap_wstrb), 32'b1100);
        run_txn(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 1, 32'd0, 1'b0);
        check("sw bus_wstrb", 32'(cap_wstrb), 32'b1111);

        run_txn(1'b0, 3'b010, 32'h102, 32'd0, 1, 32'h1111_1111, 1'b0);
        check("mis lw ready cycle", 32'(cap_ready_cycle), 32'd1);
        check("mis lw fault", 32'(mem_fault), 32'd1);
        check("mis lw rdata", mem_rdata, 32'd0);
        check("mis lw req cycles", 32'(cap_req_cycles), 32'd0);
        run_txn(1'b1, 3'b101, 32'h200, 32'h1234, 1, 32'd0, 1'b0);
        check("sh f3=101 ready cycle", 32'(cap_ready_cycle), 32'd1);
        check("sh f3=101 fault", 32'(mem_fault), 32'd1);
        check("sh f3=101 req cycles", 32'(cap_req_cycles), 32'd0);
        run_txn(1'b0, 3'b011, 32'h100, 32'd0, 1, 32'd0, 1'b0);
        check("f3=011 fault", 32'(mem_fault), 32'd1);

        run_txn(1'b0, 3'b010, 32'h400, 32'd0, 0, 32'd0, 1'b0);
        check("timeout req cycles", 32'(cap_req_cycles), 32'd4);
        check("timeout ready cycle", 32'(cap_ready_cycle), 32'd5);
        check("timeout fault", 32'(mem_fault), 32'd1);
        run_txn(1'b0, 3'b010, 32'h404, 32'd0, 4, 32'h7654_3210, 1'b0);
        check("ack last cycle fault", 32'(mem_fault), 32'd0);
        check("ack last cycle rdata", mem_rdata, 32'h7654_3210);
        run_txn(1'b0, 3'b010, 32'h408, 32'd0, 1, 32'h5555_AAAA, 1'b1);
        check("bus_err fault", 32'(mem_fault), 32'd1);
        check("bus_err rdata", mem_rdata, 32'd0);

        // Reset while in REQ
        @(posedge clk); #1;
        mem_stage_valid = 1'b1;
        mem_write  = 1'b0;
        mem_funct3 = 3'b010;
        mem_addr   = 32'h500;
        @(posedge clk); #1;
        exp_req  = 1'b1;
        exp_addr = 32'h500;
        exp_we   = 1'b0;
        exp_wstrb = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_stage_valid = 1'b0;
        exp_req   = 1'b0;
        exp_ready = 1'b0;
        exp_rdata = 32'd0;
        exp_fault = 1'b0;
        check("rst in req bus_req", 32'(bus_req), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst in req no ready", 32'(mem_stage_ready), 32'd0);
        run_txn(1'b0, 3'b010, 32'h600, 32'd0, 1, 32'h0BAD_F00D, 1'b0);
        check("lw after reset rdata", mem_rdata, 32'h0BAD_F00D);
        check("lw after reset ready cycle", 32'(cap_ready_cycle), 32'd2);

        repeat (2) @(posedge clk);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
